seq_pattern_gen: RTL and testbench

SEQ_PATTERN_GEN -- requirements
Module: seq_pattern_gen

---
 rtl/seq_pattern_gen.sv | 128 ++++++++++++
 tb/tb_seq_pattern_gen.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_pattern_gen.sv
// Serial pattern generator: shifts a captured PAT_W-bit pattern out MSB first,
// repeated repeat_n times (0 means 1) with gap_n zero bits between repetitions,
// then pulses done for one cycle.
module seq_pattern_gen #(
  parameter int unsigned PAT_W = 4,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic [CNT_W-1:0] repeat_n,
  input  logic [CNT_W-1:0] gap_n,
  output logic             x,
  output logic             x_valid,
  output logic             busy,
  output logic             done
);

  localparam int unsigned BitW = $clog2(PAT_W) + 1;
  localparam logic [BitW-1:0] BitLast = BitW'(PAT_W - 1);

  typedef enum logic [1:0] {StIdle, StSend, StGap, StDone} state_e;

  state_e             state_q, state_d;
  logic [PAT_W-1:0]   shift_q, shift_d;
  logic [PAT_W-1:0]   pat_q, pat_d;
  logic [BitW-1:0]    bit_q, bit_d;    // bits left in this repetition, minus one
  logic [CNT_W-1:0]   rep_q, rep_d;    // repetitions left after the current one
  logic [CNT_W-1:0]   gap_q, gap_d;    // captured gap length
  logic [CNT_W-1:0]   gcnt_q, gcnt_d;  // gap cycles left, minus one

  // State and datapath registers, all cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      shift_q <= '0;
      pat_q   <= '0;
      bit_q   <= '0;
      rep_q   <= '0;
      gap_q   <= '0;
      gcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      pat_q   <= pat_d;
      bit_q   <= bit_d;
      rep_q   <= rep_d;
      gap_q   <= gap_d;
      gcnt_q  <= gcnt_d;
    end
  end

  // Next-state, counter updates and state-decoded outputs.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    pat_d   = pat_q;
    bit_d   = bit_q;
    rep_d   = rep_q;
    gap_d   = gap_q;
    gcnt_d  = gcnt_q;
    x       = 1'b0;
    x_valid = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;

    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StSend;
          pat_d   = pattern;
          shift_d = pattern;
          bit_d   = BitLast;
          // A repeat count of zero behaves like one.
          rep_d   = (repeat_n == '0) ? '0 : repeat_n - CNT_W'(1);
          gap_d   = gap_n;
        end
      end

      StSend: begin
        x       = shift_q[PAT_W-1];
        x_valid = 1'b1;
        busy    = 1'b1;
        if (bit_q == '0) begin
          bit_d = BitLast;
          if (rep_q == '0) begin
            state_d = StDone;
            shift_d = '0;
            bit_d   = '0;
          end else if (gap_q != '0) begin
            state_d = StGap;
            gcnt_d  = gap_q - CNT_W'(1);
            shift_d = '0;
          end else begin
            // No gap: reload and keep sending without a bubble.
            shift_d = pat_q;
            rep_d   = rep_q - CNT_W'(1);
          end
        end else begin
          shift_d = shift_q << 1;
          bit_d   = bit_q - BitW'(1);
        end
      end

      StGap: begin
        x_valid = 1'b1;
        busy    = 1'b1;
        if (gcnt_q == '0) begin
          state_d = StSend;
          shift_d = pat_q;
          bit_d   = BitLast;
          rep_d   = rep_q - CNT_W'(1);
        end else begin
          gcnt_d = gcnt_q - CNT_W'(1);
        end
      end

      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Scoreboard bench for seq_pattern_gen: expected stream symbols are queued at
// launch time and popped by a monitor sampling on the falling clock edge.
module tb_seq_pattern_gen;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] pattern = '0;
  logic [3:0] repeat_n = '0;
  logic [3:0] gap_n = '0;
  logic       x, x_valid, busy, done;

  seq_pattern_gen #(
    .PAT_W(4),
    .CNT_W(4)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .pattern (pattern),
    .repeat_n(repeat_n),
    .gap_n   (gap_n),
    .x       (x),
    .x_valid (x_valid),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int exp_q[$];      // 0/1 = stream bit, 2 = done pulse
  int len_q[$];      // expected busy cycles per transmission
  int busy_cnt = 0;
  int det_cnt = 0;
  logic [3:0] hist = '0;
  int cyc = 0;
  int last_done = -1;
  bit b2b_chk = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: the symbol sequence one transmission should produce.
  task automatic push_exp(input logic [3:0] p, input int rep, input int gap);
    int r;
    r = (rep == 0) ? 1 : rep;
    for (int k = 0; k < r; k++) begin
      for (int i = 3; i >= 0; i--) exp_q.push_back(int'(p[i]));
      if (k < r - 1) for (int g = 0; g < gap; g++) exp_q.push_back(0);
    end
    exp_q.push_back(2);
    len_q.push_back(r * 4 + (r - 1) * gap);
  endtask

  // Pulse start for one cycle, then scramble the inputs to show they were captured.
  task automatic launch(input logic [3:0] p, input int rep, input int gap);
    @(posedge clk);
    #1;
    pattern  = p;
    repeat_n = 4'(rep);
    gap_n    = 4'(gap);
    start    = 1'b1;
    push_exp(p, rep, gap);
    @(posedge clk);
    #1;
    start    = 1'b0;
    pattern  = ~p;
    repeat_n = 4'd9;
    gap_n    = 4'd5;
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && (exp_q.size() != 0 || len_q.size() != 0); i++) @(posedge clk);
    check_eq("drain", exp_q.size() + len_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  // Output monitor, sampled mid-cycle.
  always @(negedge clk) begin : monitor
    int e;
    cyc++;
    if (!rst_n) begin
      busy_cnt = 0;
    end else begin
      check_eq("busy_vs_valid", busy, x_valid);
      if (!x_valid) check_eq("x_quiet", x, 0);
      if (busy) busy_cnt++;
      if (x_valid || done) begin
        check_eq("exp_pending", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check_eq("stream", done ? 2 : int'(x), e);
        end
      end
      if (x_valid) begin
        if (b2b_chk && last_done >= 0) begin
          check_eq("b2b_spacing", cyc - last_done, 2);
          last_done = -1;
        end
        hist = {hist[2:0], x};
        if (hist == 4'b1011) det_cnt++;
      end
      if (done) begin
        check_eq("len_pending", len_q.size() != 0, 1);
        if (len_q.size() != 0) check_eq("busy_len", busy_cnt, len_q.pop_front());
        busy_cnt  = 0;
        last_done = cyc;
        hist      = '0;
      end
    end
  end

  initial begin
    #1;
    check_eq("rst_x", x, 0);
    check_eq("rst_x_valid", x_valid, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back repetitions, no gap; count embedded 1011 matches.
    det_cnt = 0;
    launch(4'b1011, 3, 0);
    drain();
    check_eq("det_1011", det_cnt, 3);

    // Two repetitions with a two-bit gap.
    launch(4'b1011, 2, 2);
    drain();

    // Zero repeat count behaves as one; gap unused.
    launch(4'b1100, 0, 3);
    drain();

    // Restart attempt and input changes while busy are ignored.
    launch(4'b1101, 2, 1);
    @(posedge clk);
    #1;
    start    = 1'b1;
    pattern  = 4'b0000;
    repeat_n = 4'd15;
    @(posedge clk);
    #1;
    start = 1'b0;
    drain();
    repeat (5) @(posedge clk);

    // Reset during the third bit aborts without a done pulse.
    launch(4'b1011, 1, 0);
    @(posedge clk);
    @(posedge clk);
    #2;
    check_eq("pre_rst_x", x, 1);
    rst_n = 1'b0;
    #1;
    check_eq("abort_x", x, 0);
    check_eq("abort_x_valid", x_valid, 0);
    check_eq("abort_busy", busy, 0);
    check_eq("abort_done", done, 0);
    exp_q.delete();
    len_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    launch(4'b1011, 1, 0);
    drain();

    // Start held high: DONE then one IDLE cycle between transmissions.
    @(posedge clk);
    #1;
    pattern   = 4'b0110;
    repeat_n  = 4'd1;
    gap_n     = 4'd0;
    last_done = -1;
    b2b_chk   = 1'b1;
    start     = 1'b1;
    push_exp(4'b0110, 1, 0);
    push_exp(4'b0110, 1, 0);
    repeat (8) @(posedge clk);
    #1;
    start = 1'b0;
    drain();
    b2b_chk = 1'b0;

    // A few random transmissions.
    for (int t = 0; t < 4; t++) begin
      launch(4'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      drain();
    end

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
